// File: rtl/ffd_pkg.sv
// Shared types and defaults for the ffd_arbiter slice: FSM state encoding,
// requester count, default widths and the round-robin pick helper.
package ffd_pkg;

  localparam int unsigned FFD_N_REQ    = 4;
  localparam int unsigned FFD_WIDTH    = 4;
  localparam int unsigned FFD_LOCK_MAX = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // First set request at or above ptr, wrapping 3 -> 0; lowest offset wins.
  function automatic logic [1:0] rr_pick(input logic [FFD_N_REQ-1:0] req,
                                         input logic [1:0]           ptr);
    logic [1:0] idx;
    rr_pick = ptr;
    for (int unsigned k = FFD_N_REQ; k > 0; k--) begin
      idx = ptr + 2'(k - 1);
      if (req[idx]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/ffd_en_reg.sv
// WIDTH-bit D register with write enable and asynchronous active-low reset.
module ffd_en_reg
  import ffd_pkg::*;
#(
  parameter int unsigned WIDTH = FFD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/ffd_arbiter.sv
// Round-robin arbiter writing one requester's word into a shared register.
// Optional grant locking is enabled by defining FFD_ARBITER_LOCK_EN.
module ffd_arbiter
  import ffd_pkg::*;
#(
  parameter int unsigned WIDTH    = FFD_WIDTH,
  parameter int unsigned N_REQ    = FFD_N_REQ,
  parameter int unsigned LOCK_MAX = FFD_LOCK_MAX
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] data_in,
`ifdef FFD_ARBITER_LOCK_EN
  input  logic [N_REQ-1:0]       lock,
`endif
  output logic [N_REQ-1:0]       gnt,
  output logic                   enabled,
  output logic [WIDTH-1:0]       q,
  output logic [1:0]             owner
);

  state_e           state, state_nxt;
  logic [N_REQ-1:0] gnt_nxt;
  logic [1:0]       gnt_idx, gnt_idx_nxt;
  logic [1:0]       rr_ptr, rr_ptr_nxt;
  logic [1:0]       pick;
  logic             hold;
  logic [WIDTH-1:0] d_sel;

  assign pick    = rr_pick(req, rr_ptr);
  assign enabled = |gnt;
  assign d_sel   = data_in[int'(gnt_idx)*WIDTH +: WIDTH];

`ifdef FFD_ARBITER_LOCK_EN
  localparam int unsigned LCW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  logic [LCW-1:0] lock_cnt;

  // lock_cnt counts GRANT cycles already completed; release on the LOCK_MAX-th.
  assign hold = lock[gnt_idx] && ((32'(lock_cnt) + 32'd1) < LOCK_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       lock_cnt <= '0;
    else if ((state == GRANT) && hold) lock_cnt <= lock_cnt + 1'b1;
    else                              lock_cnt <= '0;
  end
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    gnt_idx_nxt = gnt_idx;
    rr_ptr_nxt  = rr_ptr;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt          = GRANT;
          gnt_idx_nxt        = pick;
          gnt_nxt            = '0;
          gnt_nxt[pick]      = 1'b1;
        end
      end
      GRANT: begin
        if (!hold) begin
          state_nxt  = IDLE;
          gnt_nxt    = '0;
          rr_ptr_nxt = gnt_idx + 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      gnt     <= '0;
      gnt_idx <= '0;
      rr_ptr  <= '0;
      owner   <= '0;
    end else begin
      state   <= state_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= gnt_idx_nxt;
      rr_ptr  <= rr_ptr_nxt;
      if (enabled) owner <= gnt_idx;
    end
  end

  ffd_en_reg #(.WIDTH(WIDTH)) u_reg (
    .clk   (clk),
    .reset (reset),
    .en    (enabled),
    .d     (d_sel),
    .q     (q)
  );

endmodule

// File: tb/tb_ffd_arbiter.sv
// Self-checking bench for ffd_arbiter: vector table plus reset, round-robin,
// mid-grant reset and (with FFD_ARBITER_LOCK_EN) lock sequences.
module tb_ffd_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] data_in;
  logic [3:0]  gnt;
  logic        enabled;
  logic [3:0]  q;
  logic [1:0]  owner;
`ifdef FFD_ARBITER_LOCK_EN
  logic [3:0]  lock;
`endif

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] data;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic [1:0]  owner;
  } vec_t;

  vec_t vecs[7];
  vec_t sb[$];
  logic [3:0] q_sb[$];

  ffd_arbiter #(.WIDTH(4), .LOCK_MAX(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .data_in (data_in),
`ifdef FFD_ARBITER_LOCK_EN
    .lock    (lock),
`endif
    .gnt     (gnt),
    .enabled (enabled),
    .q       (q),
    .owner   (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    req   = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    vec_t       e;
    logic [3:0] eq;

    reset   = 1'b0;
    req     = 4'b1111;
    data_in = 16'h4321;
`ifdef FFD_ARBITER_LOCK_EN
    lock    = '0;
`endif
    // rr_ptr after each entry follows from the previous grant
    vecs[0] = '{4'b0100, 16'h0A00, 4'b0100, 4'hA, 2'd2};
    vecs[1] = '{4'b0011, 16'h0021, 4'b0001, 4'h1, 2'd0};
    vecs[2] = '{4'b1001, 16'h7008, 4'b1000, 4'h7, 2'd3};
    vecs[3] = '{4'b0110, 16'h0C50, 4'b0010, 4'h5, 2'd1};
    vecs[4] = '{4'b1111, 16'h4321, 4'b0100, 4'h3, 2'd2};
    vecs[5] = '{4'b1111, 16'hFEDC, 4'b1000, 4'hF, 2'd3};
    vecs[6] = '{4'b0001, 16'h0005, 4'b0001, 4'h5, 2'd0};

    // Held in reset with all requests active
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_en", 32'(enabled), 32'h0);
      check("rst_q", 32'(q), 32'h0);
      check("rst_owner", 32'(owner), 32'h0);
    end
    req   = '0;
    reset = 1'b1;

    // Vector table: one transaction per entry
    for (int i = 0; i < 7; i++) begin
      req     = vecs[i].req;
      data_in = vecs[i].data;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(e.gnt));
      check($sformatf("vec%0d_en", i), 32'(enabled), 32'h1);
      req = '0;
      @(negedge clk);
      check($sformatf("vec%0d_q", i), 32'(q), 32'(e.q));
      check($sformatf("vec%0d_owner", i), 32'(owner), 32'(e.owner));
      check($sformatf("vec%0d_gnt_off", i), 32'(gnt), 32'h0);
    end

    // No requests: register holds the last write
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_en", 32'(enabled), 32'h0);
      check("hold_q", 32'(q), 32'h5);
      check("hold_owner", 32'(owner), 32'h0);
    end

    // Round robin with all requesting, rr_ptr restarted at 0
    apply_reset();
    data_in = 16'h4321;
    req     = 4'b1111;
    for (int i = 0; i < 5; i++) q_sb.push_back(4'((i % 4) + 1));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c % 2 == 0) begin
        check($sformatf("rr%0d_gnt", c), 32'(gnt), 32'(1) << ((c / 2) % 4));
      end else begin
        check($sformatf("rr%0d_gap", c), 32'(gnt), 32'h0);
        eq = (q_sb.size() > 0) ? q_sb.pop_front() : 4'hx;
        check($sformatf("rr%0d_q", c), 32'(q), 32'(eq));
      end
    end
    check("rr_sb_empty", 32'(q_sb.size()), 32'h0);
    req = '0;

    // Reset during GRANT discards the pending write
    apply_reset();
    req     = 4'b0001;
    data_in = 16'h000F;
    @(negedge clk);
    check("mrst_gnt_before", 32'(gnt), 32'h1);
    #2 reset = 1'b0;
    #1;
    check("mrst_gnt_async", 32'(gnt), 32'h0);
    check("mrst_en_async", 32'(enabled), 32'h0);
    check("mrst_q_async", 32'(q), 32'h0);
    @(negedge clk);
    check("mrst_q_held", 32'(q), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_regrant", 32'(gnt), 32'h1);
    @(negedge clk);
    check("mrst_q_after", 32'(q), 32'hF);
    check("mrst_owner_after", 32'(owner), 32'h0);
    req = '0;

`ifdef FFD_ARBITER_LOCK_EN
    // Locked requester 1 is held for exactly 8 cycles, then requester 2 follows
    apply_reset();
    req     = 4'b0110;
    lock    = 4'b0010;
    data_in = 16'h0000;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      check($sformatf("lock%0d_gnt", j), 32'(gnt), 32'h2);
      if (j > 0) begin
        eq = (q_sb.size() > 0) ? q_sb.pop_front() : 4'hx;
        check($sformatf("lock%0d_q", j), 32'(q), 32'(eq));
      end
      data_in[7:4] = 4'(j + 1);
      q_sb.push_back(4'(j + 1));
    end
    @(negedge clk);
    check("lock_release_gnt", 32'(gnt), 32'h0);
    eq = (q_sb.size() > 0) ? q_sb.pop_front() : 4'hx;
    check("lock_release_q", 32'(q), 32'(eq));
    check("lock_release_owner", 32'(owner), 32'h1);
    @(negedge clk);
    check("lock_next_gnt", 32'(gnt), 32'h4);
    req  = '0;
    lock = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
